// File: rtl/dds_addr_gen.sv
// dds_addr_gen: DDS phase accumulator, waveform-table loader and RAM address sequencer.
// Define DDS_DITHER_EN to add LFSR phase dither ahead of address truncation.
module dds_addr_gen #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_DEPTH  = 1024,
  parameter int unsigned PHASE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_load,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [DATA_WIDTH-1:0]  ld_data,
  input  logic                   ld_last,
  input  logic                   run_en,
  input  logic                   sync_clr,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] cfg_ftw,
  input  logic [PHASE_WIDTH-1:0] cfg_pow,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0]  ram_din,
  output logic                   ram_wrn,
  input  logic [DATA_WIDTH-1:0]  ram_dout,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   table_ok,
  output logic                   busy
);
  localparam int unsigned SHIFT_W = PHASE_WIDTH - ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_din_q, ram_din_d;
  logic                    ram_wrn_q, ram_wrn_d;
  logic                    issue_q, issue_d;
  logic                    out_valid_q, out_valid_d;
  logic                    table_ok_q, table_ok_d;
  logic [PHASE_WIDTH-1:0]  acc_q, acc_d;
  logic [PHASE_WIDTH-1:0]  ftw_q, ftw_d;
  logic [PHASE_WIDTH-1:0]  pow_q, pow_d;

  logic                    ld_beat_c;
  logic                    ld_end_c;
  logic                    cfg_accept_c;
  logic [PHASE_WIDTH-1:0]  phase_c;
  logic [ADDR_WIDTH-1:0]   addr_c;

  assign ld_ready     = (state_q == S_LOAD);
  assign cfg_ready    = (state_q != S_LOAD);
  assign busy         = (state_q == S_LOAD);
  assign ld_beat_c    = (state_q == S_LOAD) && ld_valid;
  assign ld_end_c     = ld_beat_c && (ld_last || (ptr_q == ADDR_WIDTH'(DATA_DEPTH - 1)));
  assign cfg_accept_c = cfg_valid && cfg_ready;

`ifdef DDS_DITHER_EN
  localparam int unsigned DITH_W = (SHIFT_W < 16) ? SHIFT_W : 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb_c;

  assign lfsr_fb_c = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign phase_c   = acc_q + pow_q + PHASE_WIDTH'(lfsr_q[DITH_W-1:0]);

  // Dither sequence advances only while sweeping; sync_clr restarts it.
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == S_RUN) lfsr_d = {lfsr_q[14:0], lfsr_fb_c};
    if (sync_clr)         lfsr_d = LFSR_SEED;
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign phase_c = acc_q + pow_q;
`endif

  assign addr_c = ADDR_WIDTH'(phase_c >> SHIFT_W);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start_load wins over run_en in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_load)              state_d = S_LOAD;
        else if (run_en && table_ok_q) state_d = S_RUN;
      end
      S_LOAD:  if (ld_end_c) state_d = S_IDLE;
      S_RUN:   if (!run_en)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath
  always_comb begin
    ptr_d       = ptr_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_wrn_d   = 1'b0;
    issue_d     = 1'b0;
    out_valid_d = issue_q;
    table_ok_d  = table_ok_q;
    acc_d       = acc_q;
    ftw_d       = ftw_q;
    pow_d       = pow_q;
    case (state_q)
      S_IDLE: if (start_load) ptr_d = '0;
      S_LOAD: begin
        if (ld_beat_c) begin
          ram_addr_d = ptr_q;
          ram_din_d  = ld_data;
          ram_wrn_d  = 1'b1;
          ptr_d      = ptr_q + ADDR_WIDTH'(1);
        end
        if (ld_end_c) table_ok_d = 1'b1;
      end
      S_RUN: begin
        acc_d      = acc_q + ftw_q;
        ram_addr_d = addr_c;
        issue_d    = 1'b1;
      end
      default: ;
    endcase
    if (sync_clr) acc_d = '0;
    if (cfg_accept_c) begin
      ftw_d = cfg_ftw;
      pow_d = cfg_pow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_wrn_q   <= 1'b0;
      issue_q     <= 1'b0;
      out_valid_q <= 1'b0;
      table_ok_q  <= 1'b0;
      acc_q       <= '0;
      ftw_q       <= '0;
      pow_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_wrn_q   <= ram_wrn_d;
      issue_q     <= issue_d;
      out_valid_q <= out_valid_d;
      table_ok_q  <= table_ok_d;
      acc_q       <= acc_d;
      ftw_q       <= ftw_d;
      pow_q       <= pow_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_wrn   = ram_wrn_q;
  assign out_valid = out_valid_q;
  assign out_data  = ram_dout;
  assign table_ok  = table_ok_q;

endmodule

// File: tb/tb_dds_addr_gen.sv
// tb_dds_addr_gen: directed bench for dds_addr_gen with a NO CHANGE single-port RAM model.
module tb_dds_addr_gen;
  logic        clk = 1'b0;
  logic        rst, start_load, ld_valid, ld_ready, ld_last, run_en, sync_clr;
  logic        cfg_valid, cfg_ready, ram_wrn, out_valid, table_ok, busy;
  logic [31:0] ld_data, cfg_ftw, cfg_pow, ram_din, ram_dout, out_data;
  logic [9:0]  ram_addr;
  logic [31:0] mem [1024];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dds_addr_gen dut (
    .clk(clk), .rst(rst), .start_load(start_load), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .run_en(run_en), .sync_clr(sync_clr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ftw(cfg_ftw), .cfg_pow(cfg_pow),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_wrn(ram_wrn), .ram_dout(ram_dout),
    .out_valid(out_valid), .out_data(out_data), .table_ok(table_ok), .busy(busy)
  );

  // Waveform RAM: NO CHANGE mode, 1-cycle read latency
  always @(posedge clk) begin
    if (ram_wrn) mem[ram_addr] <= ram_din;
    else         ram_dout <= mem[ram_addr];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start_load = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; run_en = 1'b0;
    sync_clr = 1'b0; cfg_valid = 1'b0; ld_data = '0; cfg_ftw = '0; cfg_pow = '0;
    step(); step();
    rst = 1'b0;
    checks++; if (ram_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got %0h exp 0", ram_addr); end
    checks++; if (ram_din !== 32'd0) begin errors++; $display("FAIL reset_din got %0h exp 0", ram_din); end
    checks++; if (ram_wrn !== 1'b0) begin errors++; $display("FAIL reset_wrn got %0b exp 0", ram_wrn); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (table_ok !== 1'b0) begin errors++; $display("FAIL reset_table_ok got %0b exp 0", table_ok); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready got %0b exp 0", ld_ready); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %0b exp 1", cfg_ready); end
  endtask

  task automatic test_run_no_table;
    run_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || ram_addr !== 10'd0) begin
        errors++; $display("FAIL run_no_table busy=%0b out_valid=%0b addr=%0d exp 0/0/0", busy, out_valid, ram_addr);
      end
    end
    start_load = 1'b1;
    step();
    start_load = 1'b0; run_en = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_priority busy got %0b exp 1", busy); end
  endtask

  task automatic test_reset_mid_load;
    logic [31:0] d [3];
    d[0] = 32'hAA; d[1] = 32'hBB; d[2] = 32'hCC;
    ld_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ld_data = d[i];
      step();
      checks++;
      if (ram_wrn !== 1'b1 || ram_addr !== 10'(i) || ram_din !== d[i]) begin
        errors++; $display("FAIL abort_beat%0d wrn=%0b addr=%0d din=%0h exp 1/%0d/%0h", i, ram_wrn, ram_addr, ram_din, i, d[i]);
      end
    end
    ld_data = d[2]; cfg_valid = 1'b1; cfg_ftw = 32'h1234; cfg_pow = 32'h5678;
    #1;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_in_load got %0b exp 0", cfg_ready); end
    rst = 1'b1;
    step();
    rst = 1'b0; ld_valid = 1'b0; cfg_valid = 1'b0;
    checks++; if (ram_wrn !== 1'b0) begin errors++; $display("FAIL abort_wrn got %0b exp 0", ram_wrn); end
    checks++; if (table_ok !== 1'b0) begin errors++; $display("FAIL abort_table_ok got %0b exp 0", table_ok); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", busy); end
  endtask

  task automatic test_load_beats;
    logic [31:0] d [4];
    d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33; d[3] = 32'h44;
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        ld_valid = 1'b0;
        step();
        checks++; if (ram_wrn !== 1'b0) begin errors++; $display("FAIL load_gap_wrn got %0b exp 0", ram_wrn); end
      end
      ld_valid = 1'b1; ld_data = d[i]; ld_last = (i == 3);
      step();
      checks++;
      if (ram_wrn !== 1'b1 || ram_addr !== 10'(i) || ram_din !== d[i]) begin
        errors++; $display("FAIL load_beat%0d wrn=%0b addr=%0d din=%0h exp 1/%0d/%0h", i, ram_wrn, ram_addr, ram_din, i, d[i]);
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy got %0b exp 0", busy); end
    checks++; if (table_ok !== 1'b1) begin errors++; $display("FAIL load_table_ok got %0b exp 1", table_ok); end
    step();
    checks++; if (ram_wrn !== 1'b0) begin errors++; $display("FAIL load_after_wrn got %0b exp 0", ram_wrn); end
  endtask

  task automatic test_full_load;
    start_load = 1'b1;
    step();
    start_load = 1'b0; ld_valid = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      ld_data = 32'h5A5A0000 ^ 32'(i);
      step();
      checks++;
      if (ram_wrn !== 1'b1 || ram_addr !== 10'(i) || ram_din !== (32'h5A5A0000 ^ 32'(i))) begin
        errors++; $display("FAIL full_beat%0d wrn=%0b addr=%0d din=%0h", i, ram_wrn, ram_addr, ram_din);
      end
    end
    ld_data = 32'hDEAD;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy got %0b exp 0", busy); end
    checks++; if (table_ok !== 1'b1) begin errors++; $display("FAIL full_table_ok got %0b exp 1", table_ok); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL full_ld_ready got %0b exp 0", ld_ready); end
    step();
    ld_valid = 1'b0;
    checks++;
    if (ram_wrn !== 1'b0 || ram_addr !== 10'd1023) begin
      errors++; $display("FAIL full_extra_beat wrn=%0b addr=%0d exp 0/1023", ram_wrn, ram_addr);
    end
  endtask

  task automatic test_unit_step;
    sync_clr = 1'b1; cfg_valid = 1'b1; cfg_ftw = 32'h0040_0000; cfg_pow = '0;
    step();
    sync_clr = 1'b0; cfg_valid = 1'b0; run_en = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unit_entry_valid got %0b exp 0", out_valid); end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (ram_addr !== 10'(i) || ram_wrn !== 1'b0 || out_valid !== (i != 0)) begin
        errors++; $display("FAIL unit_addr%0d addr=%0d wrn=%0b valid=%0b exp %0d/0/%0b", i, ram_addr, ram_wrn, out_valid, i, i != 0);
      end
      if (i != 0) begin
        checks++;
        if (out_data !== (32'h5A5A0000 ^ 32'(i - 1))) begin
          errors++; $display("FAIL unit_data%0d got %0h exp %0h", i, out_data, 32'h5A5A0000 ^ 32'(i - 1));
        end
      end
    end
    run_en = 1'b0;
    step(); step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unit_exit_valid got %0b exp 0", out_valid); end

    sync_clr = 1'b1; cfg_valid = 1'b1; cfg_ftw = 32'h0080_0000; cfg_pow = '0;
    step();
    sync_clr = 1'b0; cfg_valid = 1'b0; run_en = 1'b1;
    step();
    for (int i = 0; i <= 512; i++) begin
      step();
      checks++;
      if (ram_addr !== 10'((2 * i) % 1024)) begin
        errors++; $display("FAIL step2_addr%0d got %0d exp %0d", i, ram_addr, (2 * i) % 1024);
      end
    end
    run_en = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_phase_offset;
    sync_clr = 1'b1; cfg_valid = 1'b1; cfg_ftw = 32'h0040_0000; cfg_pow = 32'h8000_0000;
    step();
    sync_clr = 1'b0; cfg_valid = 1'b0; run_en = 1'b1;
    step();
    for (int i = 0; i < 514; i++) begin
      step();
      checks++;
      if (ram_addr !== 10'((512 + i) % 1024)) begin
        errors++; $display("FAIL pow_addr%0d got %0d exp %0d", i, ram_addr, (512 + i) % 1024);
      end
      if (i != 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== (32'h5A5A0000 ^ 32'((511 + i) % 1024))) begin
          errors++; $display("FAIL pow_data%0d valid=%0b data=%0h exp 1/%0h", i, out_valid, out_data, 32'h5A5A0000 ^ 32'((511 + i) % 1024));
        end
      end
    end
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    checks++; if (ram_addr !== 10'd2) begin errors++; $display("FAIL sync_clr_edge_addr got %0d exp 2", ram_addr); end
    step();
    checks++; if (ram_addr !== 10'd512) begin errors++; $display("FAIL sync_clr_addr got %0d exp 512", ram_addr); end
    step();
    checks++; if (ram_addr !== 10'd513) begin errors++; $display("FAIL sync_clr_next got %0d exp 513", ram_addr); end
  endtask

  task automatic test_cfg_timing;
    cfg_valid = 1'b1; cfg_ftw = 32'h0080_0000; cfg_pow = 32'h8000_0000;
    step();
    cfg_valid = 1'b0;
    checks++; if (ram_addr !== 10'd514) begin errors++; $display("FAIL cfg_k_addr got %0d exp 514", ram_addr); end
    step();
    checks++; if (ram_addr !== 10'd515) begin errors++; $display("FAIL cfg_k1_addr got %0d exp 515", ram_addr); end
    step();
    checks++; if (ram_addr !== 10'd517) begin errors++; $display("FAIL cfg_k2_addr got %0d exp 517", ram_addr); end
    run_en = 1'b0;
    step(); step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cfg_exit_valid got %0b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_run_no_table();
    test_reset_mid_load();
    test_load_beats();
    test_full_load();
    test_unit_step();
    test_phase_offset();
    test_cfg_timing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_addr_gen.md
# dds_addr_gen

Phase-accumulator front end of the DDS path. It drives the single-port waveform RAM's address, write-data and write-enable pins, and returns the RAM read data as a qualified sample stream. The block has two jobs: loading the waveform table through a valid/ready stream, and sweeping the table at a programmable frequency and phase offset. It sits directly upstream of the waveform RAM, which is used in NO CHANGE mode with 1-cycle read latency.

## Interface
Parameters:
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 10, RAM address width
- DATA_DEPTH, 1024, table length; must equal 2**ADDR_WIDTH
- PHASE_WIDTH, 32, accumulator width; must be greater than ADDR_WIDTH

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_load  in  1  pulse; request table load
- ld_valid / ld_ready  in / out  1 / 1  load-stream handshake
- ld_data  in  DATA_WIDTH  table word
- ld_last  in  1  marks the final load word
- run_en  in  1  level; sweep while high
- sync_clr  in  1  pulse; zero the accumulator
- cfg_valid / cfg_ready  in / out  1 / 1  tuning-update handshake
- cfg_ftw  in  PHASE_WIDTH  frequency tuning word
- cfg_pow  in  PHASE_WIDTH  phase offset word
- ram_addr  out  ADDR_WIDTH  RAM address (registered)
- ram_din  out  DATA_WIDTH  RAM write data (registered)
- ram_wrn  out  1  RAM write enable, high = write (registered)
- ram_dout  in  DATA_WIDTH  RAM read data
- out_valid  out  1  out_data qualifier
- out_data  out  DATA_WIDTH  sample; equals ram_dout
- table_ok  out  1  a table load has completed since reset
- busy  out  1  state is LOAD

## Operation
- States: IDLE, LOAD, RUN. Reset enters IDLE.
- IDLE:
  - start_load moves to LOAD and clears the load pointer to 0. start_load has priority over run_en.
  - run_en with table_ok=1 moves to RUN.
  - run_en with table_ok=0 is ignored.
- LOAD:
  - ld_ready=1. Each ld_valid&ld_ready beat registers ram_addr=ptr, ram_din=ld_data, ram_wrn=1, then increments ptr.
  - The beat with ld_last, or the beat at ptr=DATA_DEPTH-1, ends the load: next state IDLE, table_ok set.
  - ld_valid low: ram_wrn=0 and ptr holds.
  - start_load and run_en are ignored.
- RUN:
  - Each cycle: acc <= acc + ftw, wrapping modulo 2**PHASE_WIDTH.
  - ram_addr <= (acc + pow)[PHASE_WIDTH-1 -: ADDR_WIDTH], using the pre-increment acc, with modulo-wrap addition.
  - ram_wrn=0.
  - run_en low returns to IDLE on the next edge. acc is retained.
- sync_clr sets acc to 0 in any state. In RUN it takes priority over the increment for that cycle.
- Tuning update:
  - cfg_ready = (state != LOAD).
  - On accept, ftw/pow register, and they are used from the following cycle.
  - Reset value of ftw and pow is 0.
- out_valid is high one cycle after every RUN address issue. out_data is ram_dout (RAM latency 1).

## Timing
- Reset values:
  - ram_addr=0, ram_din=0, ram_wrn=0
  - out_valid=0, table_ok=0, busy=0
  - ld_ready=0, cfg_ready=1
  - acc=0, ftw=0, pow=0
- Reset mid-LOAD aborts the load: table_ok=0 and ram_wrn drops on the same edge. RAM contents are not the block's concern.
- Write latency: a beat accepted at edge k appears on the RAM pins during cycle k+1.
- Read latency: the first RUN edge issues an address. out_valid rises one cycle later. A sweep yields one sample per cycle.
- Leaving RUN: out_valid falls one cycle after the last address issue.
- Accept at edge k: the first address using the new ftw/pow is issued at edge k+2.

## Configuration
- DDS_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances each RUN cycle.
  - Its low min(16, PHASE_WIDTH-ADDR_WIDTH) bits are added, zero-extended, to (acc+pow) before truncation.
  - The LFSR reseeds on rst and sync_clr.
- Undefined: plain truncation with no LFSR logic. The Test plan values below assume undefined.

## Test plan
- Load beats: start_load, then 4 beats 0x11..0x44 with ld_last on beat 4 -> ram_wrn pulses at addr 0..3 with those data, busy falls, table_ok=1.
- Full-depth load: 1024 beats without ld_last -> final write to addr 1023, then IDLE, table_ok=1. The 1025th ld_valid is not accepted.
- Unit step: ftw=2**22, pow=0, run_en -> ram_addr 0,1,2,…; out_valid high from the second RUN cycle. ftw=2**23 -> 0,2,…,1022,0 wraps.
- Phase offset: pow=2**31, ftw=2**22 -> ram_addr 512,513,…,1023,0. sync_clr mid-sweep -> next address 512.
- Run without table: run_en before any load -> state stays IDLE, out_valid=0. start_load and run_en in the same cycle -> LOAD.
- Reset mid-load: rst after beat 2 -> ram_wrn=0 next cycle, table_ok=0. cfg_valid during LOAD sees cfg_ready=0.
